// File: rtl/sha3_feed_ctrl_if.sv
// sha3_feed_ctrl_if: message stream, core handshake and digest signals of the SHA3 feed controller.
interface sha3_feed_ctrl_if #(
  parameter int RATE_W = 1088,
  parameter int WORD_W = 64,
  parameter int OUT_W  = 256
);
  logic [WORD_W-1:0] din;
  logic              din_valid;
  logic              din_last;
  logic [3:0]        din_bytes;
  logic              din_ready;
  logic [RATE_W-1:0] core_in;
  logic              core_more;
  logic              core_in_valid;
  logic              core_hash_next;
  logic [OUT_W-1:0]  core_out;
  logic              core_out_valid;
  logic [OUT_W-1:0]  digest;
  logic              digest_valid;
  logic              busy;
  modport master (
    output din, din_valid, din_last, din_bytes, core_hash_next, core_out, core_out_valid,
    input  din_ready, core_in, core_more, core_in_valid, digest, digest_valid, busy
  );
  modport slave (
    input  din, din_valid, din_last, din_bytes, core_hash_next, core_out, core_out_valid,
    output din_ready, core_in, core_more, core_in_valid, digest, digest_valid, busy
  );
endinterface

// File: rtl/sha3_feed_ctrl.sv
// sha3_feed_ctrl: packs a 64-bit word stream into 1088-bit SHA3 rate blocks with pad10*1 and sequences them into the core.
module sha3_feed_ctrl (
  input  logic             clk,
  input  logic             rst,
  sha3_feed_ctrl_if.slave  bus
);
  localparam int RATE_W = 1088;
  localparam int WORD_W = 64;
  localparam int OUT_W  = 256;
  localparam logic [RATE_W-1:0] PAD_BLK = {8'h06, {(RATE_W-16){1'b0}}, 8'h80};
  typedef enum logic [1:0] {FILL, ISSUE, WAIT_NEXT, WAIT_OUT} state_t;
  state_t            state_q, state_d;
  logic [4:0]        widx_q, widx_d;
  logic [RATE_W-1:0] buf_q, buf_d;
  logic              more_q, more_d;
  logic              pad_pend_q, pad_pend_d;
  logic              dv_q, dv_d;
  logic [OUT_W-1:0]  digest_q, digest_d;
  logic [3:0]        nb;
  logic [7:0]        p;
  logic [WORD_W-1:0] word;
  logic [RATE_W-1:0] placed, pad_bits;
  // Non-last words always count as 8 bytes; out-of-range byte counts clamp to 8.
  assign nb       = !bus.din_last ? 4'd8 : (bus.din_bytes > 4'd8 ? 4'd8 : bus.din_bytes);
  assign word     = bus.din & ~({WORD_W{1'b1}} >> {nb, 3'b000});
  assign placed   = {word, {(RATE_W-WORD_W){1'b0}}} >> {widx_q, 6'b000000};
  assign p        = {widx_q, 3'b000} + {4'b0000, nb};
  assign pad_bits = ({8'h06, {(RATE_W-8){1'b0}}} >> {p, 3'b000}) | {{(RATE_W-8){1'b0}}, 8'h80};
  // The buffer is zero on every entry to FILL, so words and padding are simply OR-ed in.
  always_comb begin
    state_d    = state_q;
    widx_d     = widx_q;
    buf_d      = buf_q;
    more_d     = more_q;
    pad_pend_d = pad_pend_q;
    digest_d   = digest_q;
    dv_d       = 1'b0;
    case (state_q)
      FILL: if (bus.din_valid) begin
        buf_d = buf_q | placed;
        if (!bus.din_last) begin
          widx_d  = widx_q == 5'd16 ? 5'd0 : widx_q + 5'd1;
          more_d  = widx_q == 5'd16 ? 1'b1 : more_q;
          state_d = widx_q == 5'd16 ? ISSUE : FILL;
        end else begin
          widx_d     = 5'd0;
          more_d     = p == 8'd136;
          pad_pend_d = p == 8'd136;
          buf_d      = p == 8'd136 ? buf_q | placed : buf_q | placed | pad_bits;
          state_d    = ISSUE;
        end
      end
      ISSUE: state_d = more_q ? WAIT_NEXT : WAIT_OUT;
      WAIT_NEXT: if (bus.core_hash_next) begin
        buf_d      = pad_pend_q ? PAD_BLK : '0;
        more_d     = 1'b0;
        pad_pend_d = 1'b0;
        state_d    = pad_pend_q ? ISSUE : FILL;
      end
      WAIT_OUT: if (bus.core_out_valid) begin
        digest_d = bus.core_out;
        dv_d     = 1'b1;
        buf_d    = '0;
        state_d  = FILL;
      end
      default: state_d = FILL;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FILL;
      widx_q     <= '0;
      buf_q      <= '0;
      more_q     <= 1'b0;
      pad_pend_q <= 1'b0;
      dv_q       <= 1'b0;
      digest_q   <= '0;
    end else begin
      state_q    <= state_d;
      widx_q     <= widx_d;
      buf_q      <= buf_d;
      more_q     <= more_d;
      pad_pend_q <= pad_pend_d;
      dv_q       <= dv_d;
      digest_q   <= digest_d;
    end
  end
  assign bus.din_ready     = state_q == FILL;
  assign bus.core_in       = buf_q;
  assign bus.core_more     = more_q;
  assign bus.core_in_valid = state_q == ISSUE;
  assign bus.digest        = digest_q;
  assign bus.digest_valid  = dv_q;
  assign bus.busy          = !(state_q == FILL && widx_q == 5'd0);
endmodule

// File: tb/tb_sha3_feed_ctrl.sv
// tb_sha3_feed_ctrl: directed scenarios for the SHA3 feed controller with a hand-driven core model.
module tb_sha3_feed_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sha3_feed_ctrl_if bus ();
  sha3_feed_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  int vecs = 0;
  int errs = 0;
  int strobes = 0;
  always @(posedge clk) if (bus.core_in_valid === 1'b1) strobes++;
  localparam logic [255:0]  A5  = {32{8'hA5}};
  localparam logic [255:0]  ABC = 256'h3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532;
  localparam logic [1087:0] PAD = {8'h06, 1072'b0, 8'h80};

  function automatic logic [7:0] mb(input int i);
    return 8'((i * 7 + 3) & 255);
  endfunction

  function automatic logic [63:0] wd(input int w);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[63-8*b -: 8] = mb(8 * w + b);
    return r;
  endfunction

  function automatic logic [1087:0] exp_block(input int start, input int len, input bit fin);
    logic [1087:0] r;
    int p;
    r = '0;
    for (int k = 0; k < 136; k++) if (start + k < len) r[1087-8*k -: 8] = mb(start + k);
    p = len - start;
    if (fin && p <= 135) begin
      r[1087-8*p -: 8] = r[1087-8*p -: 8] | 8'h06;
      r[7:0] = r[7:0] | 8'h80;
    end
    return r;
  endfunction

  task automatic drive(input logic [63:0] d, input logic last, input logic [3:0] nb);
    bus.din = d; bus.din_valid = 1'b1; bus.din_last = last; bus.din_bytes = nb;
    @(negedge clk);
    bus.din_valid = 1'b0; bus.din_last = 1'b0; bus.din_bytes = 4'd0;
  endtask

  task automatic send_word(input int w, input int len);
    int rem;
    rem = len - 8 * w;
    drive(wd(w), rem <= 8, rem >= 8 ? 4'd8 : 4'(rem));
  endtask

  task automatic pulse_out(input logic [255:0] dg);
    @(negedge clk);
    bus.core_out = dg; bus.core_out_valid = 1'b1;
    @(negedge clk);
    bus.core_out_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vecs++; if (bus.din_ready !== 1'b1) begin errs++; $display("FAIL rst_din_ready got %b exp 1", bus.din_ready); end
    vecs++; if (bus.core_in !== '0) begin errs++; $display("FAIL rst_core_in got %h exp 0", bus.core_in[127:0]); end
    vecs++; if (bus.core_more !== 1'b0) begin errs++; $display("FAIL rst_core_more got %b exp 0", bus.core_more); end
    vecs++; if (bus.core_in_valid !== 1'b0) begin errs++; $display("FAIL rst_in_valid got %b exp 0", bus.core_in_valid); end
    vecs++; if (bus.digest !== '0) begin errs++; $display("FAIL rst_digest got %h exp 0", bus.digest); end
    vecs++; if (bus.digest_valid !== 1'b0) begin errs++; $display("FAIL rst_digest_valid got %b exp 0", bus.digest_valid); end
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_empty;
    drive(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0);
    vecs++; if (bus.core_in_valid !== 1'b1) begin errs++; $display("FAIL empty_strobe got %b exp 1", bus.core_in_valid); end
    vecs++; if (bus.core_more !== 1'b0) begin errs++; $display("FAIL empty_more got %b exp 0", bus.core_more); end
    vecs++; if (bus.core_in !== PAD) begin errs++; $display("FAIL empty_block got hi %h lo %h exp hi %h lo %h", bus.core_in[1087:960], bus.core_in[127:0], PAD[1087:960], PAD[127:0]); end
    vecs++; if (bus.din_ready !== 1'b0) begin errs++; $display("FAIL empty_ready_issue got %b exp 0", bus.din_ready); end
    vecs++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL empty_busy got %b exp 1", bus.busy); end
    @(negedge clk);
    vecs++; if (bus.core_in_valid !== 1'b0) begin errs++; $display("FAIL empty_one_strobe got %b exp 0", bus.core_in_valid); end
    bus.core_out = A5; bus.core_out_valid = 1'b1;
    @(negedge clk);
    bus.core_out_valid = 1'b0;
    vecs++; if (bus.digest_valid !== 1'b1) begin errs++; $display("FAIL empty_dv got %b exp 1", bus.digest_valid); end
    vecs++; if (bus.digest !== A5) begin errs++; $display("FAIL empty_digest got %h exp %h", bus.digest, A5); end
    @(negedge clk);
    vecs++; if (bus.digest_valid !== 1'b0) begin errs++; $display("FAIL empty_dv_pulse got %b exp 0", bus.digest_valid); end
    vecs++; if (bus.digest !== A5) begin errs++; $display("FAIL empty_digest_hold got %h exp %h", bus.digest, A5); end
    vecs++; if (bus.busy !== 1'b0 || bus.din_ready !== 1'b1) begin errs++; $display("FAIL empty_idle got busy %b ready %b exp 0 1", bus.busy, bus.din_ready); end
  endtask

  task automatic test_abc;
    drive(64'h616263A1B2C3D4E5, 1'b1, 4'd3);
    vecs++; if (bus.core_in[1087:1056] !== 32'h61626306) begin errs++; $display("FAIL abc_head got %h exp 61626306", bus.core_in[1087:1056]); end
    vecs++; if (bus.core_in[7:0] !== 8'h80) begin errs++; $display("FAIL abc_tail got %h exp 80", bus.core_in[7:0]); end
    vecs++; if (bus.core_in[1055:8] !== '0) begin errs++; $display("FAIL abc_zero got %h exp 0", bus.core_in[1055:928]); end
    vecs++; if (bus.core_more !== 1'b0 || bus.core_in_valid !== 1'b1) begin errs++; $display("FAIL abc_strobe got more %b valid %b exp 0 1", bus.core_more, bus.core_in_valid); end
    pulse_out(ABC);
    vecs++; if (bus.digest !== ABC || bus.digest_valid !== 1'b1) begin errs++; $display("FAIL abc_digest got %h dv %b exp %h dv 1", bus.digest, bus.digest_valid, ABC); end
    @(negedge clk);
  endtask

  task automatic test_p135;
    int s;
    s = strobes;
    for (int w = 0; w < 16; w++) send_word(w, 135);
    vecs++; if (strobes !== s || bus.core_in_valid !== 1'b0) begin errs++; $display("FAIL p135_early got strobes %0d exp 0", strobes - s); end
    send_word(16, 135);
    vecs++; if (bus.core_in_valid !== 1'b1 || bus.core_more !== 1'b0) begin errs++; $display("FAIL p135_strobe got valid %b more %b exp 1 0", bus.core_in_valid, bus.core_more); end
    vecs++; if (bus.core_in[7:0] !== 8'h86) begin errs++; $display("FAIL p135_tail got %h exp 86", bus.core_in[7:0]); end
    vecs++; if (bus.core_in !== exp_block(0, 135, 1'b1)) begin errs++; $display("FAIL p135_block got lo %h exp lo %h", bus.core_in[127:0], exp_block(0, 135, 1'b1)[127:0]); end
    pulse_out(A5);
    vecs++; if (strobes - s !== 1) begin errs++; $display("FAIL p135_count got %0d exp 1", strobes - s); end
    @(negedge clk);
  endtask

  task automatic test_exact_fill;
    int s;
    bit rdy;
    for (int w = 0; w < 17; w++) send_word(w, 136);
    vecs++; if (bus.core_in_valid !== 1'b1 || bus.core_more !== 1'b1) begin errs++; $display("FAIL exact_first got valid %b more %b exp 1 1", bus.core_in_valid, bus.core_more); end
    vecs++; if (bus.core_in !== exp_block(0, 136, 1'b0)) begin errs++; $display("FAIL exact_block got lo %h exp lo %h", bus.core_in[127:0], exp_block(0, 136, 1'b0)[127:0]); end
    s = strobes;
    rdy = 1'b0;
    repeat (24) begin
      @(negedge clk);
      if (bus.din_ready !== 1'b0) rdy = 1'b1;
    end
    vecs++; if (strobes - s !== 1) begin errs++; $display("FAIL exact_no_second got %0d strobes exp 1", strobes - s); end
    vecs++; if (rdy !== 1'b0) begin errs++; $display("FAIL exact_ready_wait got %b exp 0", rdy); end
    bus.core_hash_next = 1'b1;
    @(negedge clk);
    bus.core_hash_next = 1'b0;
    vecs++; if (bus.core_in_valid !== 1'b1 || bus.core_more !== 1'b0) begin errs++; $display("FAIL exact_pad_strobe got valid %b more %b exp 1 0", bus.core_in_valid, bus.core_more); end
    vecs++; if (bus.core_in !== PAD) begin errs++; $display("FAIL exact_pad_block got hi %h lo %h exp hi %h lo %h", bus.core_in[1087:960], bus.core_in[127:0], PAD[1087:960], PAD[127:0]); end
    vecs++; if (bus.din_ready !== 1'b0) begin errs++; $display("FAIL exact_pad_ready got %b exp 0", bus.din_ready); end
    pulse_out(A5);
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    bit rdy;
    for (int w = 0; w < 17; w++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_word(w, 160);
    end
    vecs++; if (bus.core_in_valid !== 1'b1 || bus.core_more !== 1'b1) begin errs++; $display("FAIL mb_first got valid %b more %b exp 1 1", bus.core_in_valid, bus.core_more); end
    vecs++; if (bus.core_in !== exp_block(0, 160, 1'b0)) begin errs++; $display("FAIL mb_block1 got lo %h exp lo %h", bus.core_in[127:0], exp_block(0, 160, 1'b0)[127:0]); end
    rdy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.din_ready !== 1'b0) rdy = 1'b1;
    end
    vecs++; if (rdy !== 1'b0) begin errs++; $display("FAIL mb_ready_wait got %b exp 0", rdy); end
    bus.core_hash_next = 1'b1;
    @(negedge clk);
    bus.core_hash_next = 1'b0;
    vecs++; if (bus.din_ready !== 1'b1 || bus.busy !== 1'b0 || bus.core_in_valid !== 1'b0) begin errs++; $display("FAIL mb_refill got ready %b busy %b valid %b exp 1 0 0", bus.din_ready, bus.busy, bus.core_in_valid); end
    send_word(17, 160);
    bus.core_hash_next = 1'b1;
    @(negedge clk);
    bus.core_hash_next = 1'b0;
    vecs++; if (bus.din_ready !== 1'b1 || bus.busy !== 1'b1 || bus.core_in_valid !== 1'b0) begin errs++; $display("FAIL mb_spurious got ready %b busy %b valid %b exp 1 1 0", bus.din_ready, bus.busy, bus.core_in_valid); end
    for (int w = 18; w < 20; w++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_word(w, 160);
    end
    vecs++; if (bus.core_in_valid !== 1'b1 || bus.core_more !== 1'b0) begin errs++; $display("FAIL mb_second got valid %b more %b exp 1 0", bus.core_in_valid, bus.core_more); end
    vecs++; if (bus.core_in !== exp_block(136, 160, 1'b1)) begin errs++; $display("FAIL mb_block2 got hi %h exp hi %h", bus.core_in[1087:896], exp_block(136, 160, 1'b1)[1087:896]); end
    pulse_out(A5);
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    drive(64'h6162630000000000, 1'b1, 4'd3);
    pulse_out(ABC);
    drive(64'h6162630000000000, 1'b1, 4'd3);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    vecs++; if (bus.din_ready !== 1'b1 || bus.busy !== 1'b0) begin errs++; $display("FAIL rmid_ctrl got ready %b busy %b exp 1 0", bus.din_ready, bus.busy); end
    vecs++; if (bus.core_in !== '0 || bus.core_more !== 1'b0 || bus.core_in_valid !== 1'b0) begin errs++; $display("FAIL rmid_core got in %h more %b valid %b exp 0", bus.core_in[1087:960], bus.core_more, bus.core_in_valid); end
    vecs++; if (bus.digest !== '0 || bus.digest_valid !== 1'b0) begin errs++; $display("FAIL rmid_digest got %h dv %b exp 0 0", bus.digest, bus.digest_valid); end
    @(negedge clk);
    rst = 1'b0;
    bus.core_out = A5; bus.core_out_valid = 1'b1;
    @(negedge clk);
    bus.core_out_valid = 1'b0;
    vecs++; if (bus.digest_valid !== 1'b0 || bus.digest !== '0) begin errs++; $display("FAIL rmid_stray_out got dv %b digest %h exp 0 0", bus.digest_valid, bus.digest); end
    drive(64'h0, 1'b1, 4'd0);
    vecs++; if (bus.core_in !== PAD || bus.core_in_valid !== 1'b1) begin errs++; $display("FAIL rmid_next_block got lo %h valid %b exp lo %h 1", bus.core_in[127:0], bus.core_in_valid, PAD[127:0]); end
    pulse_out(~A5);
    vecs++; if (bus.digest !== ~A5 || bus.digest_valid !== 1'b1) begin errs++; $display("FAIL rmid_next_digest got %h dv %b exp %h 1", bus.digest, bus.digest_valid, ~A5); end
    @(negedge clk);
  endtask

  initial begin
    bus.din = '0; bus.din_valid = 1'b0; bus.din_last = 1'b0; bus.din_bytes = 4'd0;
    bus.core_hash_next = 1'b0; bus.core_out = '0; bus.core_out_valid = 1'b0;
    test_reset;
    test_empty;
    test_abc;
    test_p135;
    test_exact_fill;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
